// File: rtl/parking_gate_if.sv
// -----------------------------------------------------------------------------
// parking_gate_if
// Groups the gate detector's sensor inputs and event outputs.
//   sensor_a : outer beam (street side), asynchronous, 1 = blocked
//   sensor_b : inner beam (lot side), asynchronous, 1 = blocked
//   entry    : one-cycle pulse, street->lot traversal completed
//   exit     : one-cycle pulse, lot->street traversal completed
//   busy     : tracking FSM is not idle
//   fault    : one-cycle pulse on a tracking timeout
// Modports: master = sensor side / consumer of events, slave = detector.
// -----------------------------------------------------------------------------
interface parking_gate_if;
  logic sensor_a;
  logic sensor_b;
  logic entry;
  logic exit;
  logic busy;
  logic fault;

  modport master (
    output sensor_a, sensor_b,
    input  entry, exit, busy, fault
  );

  modport slave (
    input  sensor_a, sensor_b,
    output entry, exit, busy, fault
  );
endinterface

// File: rtl/parking_gate_detector.sv
// -----------------------------------------------------------------------------
// parking_gate_detector
// Synchronises and debounces two series IR beams across the gate lane and
// tracks the direction of each vehicle. A complete ordered traversal yields a
// single-cycle entry or exit pulse; a stall in any tracking state yields a
// single-cycle fault pulse and the detector waits for a clear lane.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   gate  : parking_gate_if.slave (sensor_a/b in; entry/exit/busy/fault out)
// Parameters:
//   DEBOUNCE : cycles a synchronised sensor must disagree before it flips
//   TIMEOUT  : maximum cycles in one tracking state before a fault
// -----------------------------------------------------------------------------
module parking_gate_detector #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  parking_gate_if.slave  gate
);

  localparam int DbW = $clog2(DEBOUNCE + 1);
  localparam int ToW = $clog2(TIMEOUT + 1);
  // Flip/timeout happen on the edge where the counter would reach its limit.
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  // Bit 1 = sensor_a, bit 0 = sensor_b, matching the (a,b) pair notation.
  logic [1:0] raw_pair;
  logic [1:0] deb_pair;

  assign raw_pair = {gate.sensor_a, gate.sensor_b};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
    logic           sync1_q;
    logic           sync2_q;
    logic           deb_q;
    logic [DbW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_pair[gi];
        sync2_q <= sync1_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DbLast) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign deb_pair[gi] = deb_q;
  end

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, FLUSH
  } state_e;

  state_e         state_q, state_d;
  logic [ToW-1:0] tmo_q;
  logic           entry_q, exit_q, busy_q, fault_q;
  logic           entry_d, exit_d, fault_d;

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    fault_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (deb_pair)
          2'b10:   state_d = IN_A;
          2'b01:   state_d = OUT_B;
          2'b11:   state_d = FLUSH;   // both beams at once: direction unknown
          default: state_d = IDLE;
        endcase
      end
      IN_A: begin
        case (deb_pair)
          2'b00:   state_d = IDLE;
          2'b11:   state_d = IN_AB;
          2'b01:   state_d = FLUSH;
          default: state_d = IN_A;
        endcase
      end
      IN_AB: begin
        case (deb_pair)
          2'b01:   state_d = IN_B;
          2'b10:   state_d = IN_A;
          2'b00:   state_d = IDLE;
          default: state_d = IN_AB;
        endcase
      end
      IN_B: begin
        case (deb_pair)
          2'b00: begin
            state_d = IDLE;
            entry_d = 1'b1;
          end
          2'b11:   state_d = IN_AB;
          2'b10:   state_d = FLUSH;
          default: state_d = IN_B;
        endcase
      end
      OUT_B: begin
        case (deb_pair)
          2'b00:   state_d = IDLE;
          2'b11:   state_d = OUT_BA;
          2'b10:   state_d = FLUSH;
          default: state_d = OUT_B;
        endcase
      end
      OUT_BA: begin
        case (deb_pair)
          2'b10:   state_d = OUT_A;
          2'b01:   state_d = OUT_B;
          2'b00:   state_d = IDLE;
          default: state_d = OUT_BA;
        endcase
      end
      OUT_A: begin
        case (deb_pair)
          2'b00: begin
            state_d = IDLE;
            exit_d  = 1'b1;
          end
          2'b11:   state_d = OUT_BA;
          2'b01:   state_d = FLUSH;
          default: state_d = OUT_A;
        endcase
      end
      default: begin  // FLUSH
        state_d = (deb_pair == 2'b00) ? IDLE : FLUSH;
      end
    endcase

    // A real transition always wins; the timeout only fires on a stall.
    if (state_d == state_q && state_q != IDLE && state_q != FLUSH &&
        tmo_q == ToLast) begin
      state_d = FLUSH;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      fault_q <= fault_d;
      busy_q  <= (state_d != IDLE);
      if (state_d != state_q || state_d == IDLE || state_d == FLUSH) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign gate.entry = entry_q;
  assign gate.exit  = exit_q;
  assign gate.busy  = busy_q;
  assign gate.fault = fault_q;

endmodule
